// File: rtl/axis_pkt_store_fwd_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is released only once its
// tlast beat is stored; bad (tuser[0]) and oversize packets are discarded.
module axis_pkt_store_fwd_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 64,
    parameter int PKT_DEPTH  = 16
) (
    input  logic                           xdma_clk,
    input  logic                           xdma_reset,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic [USER_WIDTH-1:0]          s_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [31:0]                    pkt_pass_count,
    output logic [31:0]                    pkt_drop_count,
    output logic [$clog2(PKT_DEPTH):0]     pkt_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(PKT_DEPTH) + 1;
    localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_STORE, ST_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr, r_beat_cnt;
    logic [MW-1:0]   r_mem [DEPTH];
    logic [MW-1:0]   r_rd_word, r_sk0, r_sk1;
    logic            r_rd_vld, r_run;
    logic [1:0]      r_sk_cnt;
    logic [LW-1:0]   r_pkt_level;
    logic [31:0]     r_pass, r_drop;

    logic            w_full, w_s_ready, w_in_hs, w_store, w_commit, w_reject;
    logic            w_oversize, w_drop_end, w_pop, w_rd_en, w_out_last;
    logic [2:0]      w_occ;
    logic [1:0]      w_sk_mid;

    assign w_full     = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
    assign w_in_hs    = s_axis_tvalid & w_s_ready;
    assign w_store    = w_in_hs & (r_state != ST_DROP);
    assign w_commit   = w_store & s_axis_tlast & ~s_axis_tuser[0];
    assign w_reject   = w_store & s_axis_tlast & s_axis_tuser[0];
    assign w_oversize = w_store & ~s_axis_tlast & (r_beat_cnt == PW'(DEPTH - 1));
    assign w_drop_end = w_in_hs & (r_state == ST_DROP) & s_axis_tlast;

    always_ff @(posedge xdma_clk or posedge xdma_reset) begin
        if (xdma_reset) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_STORE: begin
                if (w_in_hs) begin
                    if (s_axis_tlast)    w_state_nxt = ST_IDLE;
                    else if (w_oversize) w_state_nxt = ST_DROP;
                    else                 w_state_nxt = ST_STORE;
                end
            end
            ST_DROP:  if (w_drop_end) w_state_nxt = ST_STORE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // r_run keeps tready low while reset is held
    always_comb begin
        w_s_ready = 1'b0;
        if (r_run) begin
            if (r_state == ST_DROP) w_s_ready = 1'b1;
            else                    w_s_ready = !w_full && (r_pkt_level < LW'(PKT_DEPTH));
        end
    end

    always_ff @(posedge xdma_clk or posedge xdma_reset) begin
        if (xdma_reset) begin
            r_run       <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_beat_cnt  <= '0;
            r_pass      <= '0;
            r_drop      <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_oversize || w_reject) r_wr_ptr <= r_wr_commit;
            else if (w_store)           r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit)               r_wr_commit <= r_wr_ptr + 1'b1;
            if (w_oversize || (w_store && s_axis_tlast)) r_beat_cnt <= '0;
            else if (w_store)                            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_commit)                r_pass <= r_pass + 1'b1;
            if (w_reject || w_drop_end)  r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge xdma_clk) begin
        if (w_store)  r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (w_rd_en)  r_rd_word <= r_mem[r_rd_ptr[AW-1:0]];
    end

    // Reads are issued so that skid entries plus the in-flight read never exceed two,
    // which sustains one beat per cycle without bubbles.
    assign w_pop      = (r_sk_cnt != 2'd0) & m_axis_tready;
    assign w_occ      = {1'b0, r_sk_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_rd_en    = (r_rd_ptr != r_wr_commit) && (w_occ < 3'd2);
    assign w_sk_mid   = r_sk_cnt - {1'b0, w_pop};
    assign w_out_last = w_pop & r_sk0[MW-1];

    always_ff @(posedge xdma_clk or posedge xdma_reset) begin
        if (xdma_reset) begin
            r_rd_ptr    <= '0;
            r_rd_vld    <= 1'b0;
            r_sk_cnt    <= '0;
            r_sk0       <= '0;
            r_sk1       <= '0;
            r_pkt_level <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_sk_cnt <= r_sk_cnt - {1'b0, w_pop} + {1'b0, r_rd_vld};
            if (w_pop) r_sk0 <= r_sk1;
            if (r_rd_vld) begin
                if (w_sk_mid == 2'd0) r_sk0 <= r_rd_word;
                else                  r_sk1 <= r_rd_word;
            end
            if (w_commit && !w_out_last)      r_pkt_level <= r_pkt_level + 1'b1;
            else if (!w_commit && w_out_last) r_pkt_level <= r_pkt_level - 1'b1;
        end
    end

    assign s_axis_tready  = w_s_ready;
    assign m_axis_tvalid  = (r_sk_cnt != 2'd0);
    assign m_axis_tlast   = r_sk0[MW-1];
    assign m_axis_tkeep   = r_sk0[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tdata   = r_sk0[DATA_WIDTH-1:0];
    assign m_axis_tuser   = '0;
    assign pkt_pass_count = r_pass;
    assign pkt_drop_count = r_drop;
    assign pkt_level      = r_pkt_level;
endmodule

// File: tb/tb_axis_pkt_store_fwd_fifo.sv
// Randomised bench for axis_pkt_store_fwd_fifo with a packet-level queue model.
module tb_axis_pkt_store_fwd_fifo;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int DEPTH = 64;
    localparam int PKT_DEPTH = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [0:0]    s_axis_tuser = '0;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [0:0]    m_axis_tuser;
    logic [31:0]   pkt_pass_count, pkt_drop_count;
    logic [LW-1:0] pkt_level;

    always #5 clk = ~clk;

    axis_pkt_store_fwd_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1),
                              .DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)) dut (
        .xdma_clk(clk), .xdma_reset(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .pkt_pass_count(pkt_pass_count), .pkt_drop_count(pkt_drop_count),
        .pkt_level(pkt_level)
    );

    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;

    beat_t exp_q[$];
    beat_t cur_pkt[$];
    int    n_chk = 0, n_fail = 0;
    int    cyc = 0;
    int    exp_pass = 0, exp_drop = 0, model_level = 0;
    int    out_beats = 0, last_hs_cyc = 0, first_valid_cyc = -1;
    bit    mid_pkt = 0, prev_stall = 0;
    beat_t prev_out;
    bit    rdy_rand = 0;
    logic  rdy_fixed = 1'b1;

    task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rdy_rand ? 1'($urandom_range(1)) : rdy_fixed;
        end
    end

    // Packet-level reference: a packet is forwarded whole if it is at most DEPTH
    // beats long and not flagged bad on its last beat; otherwise it is counted as dropped.
    always @(negedge clk) begin
        beat_t e, b;
        if (rst) begin
            exp_q.delete(); cur_pkt.delete();
            exp_pass = 0; exp_drop = 0; model_level = 0; out_beats = 0;
            mid_pkt = 0; prev_stall = 0;
        end else begin
            check("pass_count", DW'(pkt_pass_count), DW'(exp_pass));
            check("drop_count", DW'(pkt_drop_count), DW'(exp_drop));
            check("pkt_level", DW'(pkt_level), DW'(model_level));
            check("level_bound", DW'(pkt_level <= LW'(PKT_DEPTH)), DW'(1));
            check("tuser_zero", DW'(m_axis_tuser), DW'(0));
            if (cur_pkt.size() >= DEPTH) check("drop_ready", DW'(s_axis_tready), DW'(1));
            if (mid_pkt) check("no_bubble", DW'(m_axis_tvalid), DW'(1));
            if (prev_stall) begin
                check("hold_valid", DW'(m_axis_tvalid), DW'(1));
                check("hold_data", m_axis_tdata, prev_out.d);
                check("hold_keep", DW'(m_axis_tkeep), DW'(prev_out.k));
                check("hold_last", DW'(m_axis_tlast), DW'(prev_out.l));
            end
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_axis_tdata, e.d);
                    check("out_keep", DW'(m_axis_tkeep), DW'(e.k));
                    check("out_last", DW'(m_axis_tlast), DW'(e.l));
                end
                out_beats++;
                mid_pkt = !m_axis_tlast;
                if (m_axis_tlast) model_level--;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out.d = m_axis_tdata; prev_out.k = m_axis_tkeep; prev_out.l = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                b.d = s_axis_tdata; b.k = s_axis_tkeep; b.l = s_axis_tlast;
                cur_pkt.push_back(b);
                if (s_axis_tlast) begin
                    last_hs_cyc = cyc + 1;
                    if (cur_pkt.size() > DEPTH || s_axis_tuser[0]) begin
                        exp_drop++;
                    end else begin
                        foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
                        exp_pass++;
                        model_level++;
                    end
                    cur_pkt.delete();
                end
            end
        end
    end

    task automatic send_beat();
        int tries = 0;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready) begin
            tries++;
            if (tries > 3000) begin fail_timeout("s_tready"); break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    endtask

    task automatic send_pkt(input int len, input bit bad, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            for (int w = 0; w < DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom();
            s_axis_tkeep = {$urandom(), $urandom()};
            s_axis_tlast = (i == len - 1);
            s_axis_tuser = 1'(bad && (i == len - 1));
            send_beat();
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= limit) fail_timeout("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
        check("rst_m_tdata", m_axis_tdata, DW'(0));
        check("rst_m_tkeep", DW'(m_axis_tkeep), DW'(0));
        check("rst_s_tready", DW'(s_axis_tready), DW'(0));
        check("rst_pass", DW'(pkt_pass_count), DW'(0));
        check("rst_drop", DW'(pkt_drop_count), DW'(0));
        check("rst_level", DW'(pkt_level), DW'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // single 4-beat packet, output latency and contiguity
        rdy_fixed = 1'b1;
        first_valid_cyc = -1;
        send_pkt(4, 1'b0, 0);
        n = 0;
        while (first_valid_cyc < 0 && n < 50) begin @(negedge clk); #1; n++; end
        check("first_valid_latency", DW'(first_valid_cyc - last_hs_cyc), DW'(2));
        @(posedge clk); #1;
        wait_drain(200);
        check("t1_pass", DW'(pkt_pass_count), DW'(1));
        check("t1_beats", DW'(out_beats), DW'(4));

        // bad packet then good packet
        do_reset();
        send_pkt(4, 1'b1, 0);
        send_pkt(2, 1'b0, 0);
        wait_drain(200);
        check("t2_drop", DW'(pkt_drop_count), DW'(1));
        check("t2_pass", DW'(pkt_pass_count), DW'(1));
        check("t2_beats", DW'(out_beats), DW'(2));

        // oversize packet then good packet
        do_reset();
        send_pkt(70, 1'b0, 0);
        send_pkt(3, 1'b0, 0);
        wait_drain(400);
        check("t3_drop", DW'(pkt_drop_count), DW'(1));
        check("t3_pass", DW'(pkt_pass_count), DW'(1));
        check("t3_beats", DW'(out_beats), DW'(3));

        // gappy input still yields a bubble-free output packet
        do_reset();
        send_pkt(10, 1'b0, 50);
        wait_drain(200);
        check("t4_beats", DW'(out_beats), DW'(10));

        // random traffic with random backpressure
        do_reset();
        rdy_rand = 1;
        for (int p = 0; p < 200; p++)
            send_pkt(int'($urandom_range(40, 1)), ($urandom_range(7) == 0), 20);
        wait_drain(6000);
        check("t5_total", DW'(pkt_pass_count + pkt_drop_count), DW'(200));
        rdy_rand = 0;
        rdy_fixed = 1'b1;

        // reset with one packet mid-output and another mid-input
        do_reset();
        send_pkt(6, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom();
            s_axis_tkeep = {$urandom(), $urandom()};
            send_beat();
        end
        n = 0;
        while (out_beats < 3 && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) fail_timeout("t6_out_beat3");
        rst = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("t6_no_residual", DW'(out_beats), DW'(0));
        send_pkt(3, 1'b0, 0);
        wait_drain(200);
        check("t6_pass", DW'(pkt_pass_count), DW'(1));
        check("t6_beats", DW'(out_beats), DW'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axis_pkt_store_fwd_fifo.md
Name: axis_pkt_store_fwd_fifo

Overview:
Store-and-forward AXI-Stream packet FIFO inserted between the UDP TX stream and the CMAC TX input of CmacRxTxWrapper, on the XDMA AXI clock. A packet is released downstream only after its tlast beat is stored, so CMAC TX sees tvalid held high for the whole packet and never underruns mid-packet. Packets flagged bad via tuser and oversize packets are dropped; drop and pass statistics are exported.

Parameters:
DATA_WIDTH, 512, tdata width
KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
USER_WIDTH, 1, tuser width; bit 0 = bad-packet flag
DEPTH, 64, beat storage entries (power of 2, >= 4)
PKT_DEPTH, 16, max committed packets held (power of 2)

Ports:
xdma_clk  in  1  clock
xdma_reset  in  1  asynchronous reset, active-high
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tlast  in  1  input end of packet
s_axis_tuser  in  USER_WIDTH  input sideband; bit 0 sampled on tlast beat
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  KEEP_WIDTH  output byte enables
m_axis_tlast  out  1  output end of packet
m_axis_tuser  out  USER_WIDTH  always 0
pkt_pass_count  out  32  committed packets, wraps
pkt_drop_count  out  32  dropped packets, wraps
pkt_level  out  $clog2(PKT_DEPTH)+1  committed packets not yet fully sent

Behaviour:
- Reset: all pointers, counters, pkt_level = 0; s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tkeep = 0; write FSM = IDLE. Reset mid-packet discards all stored and partial data; no partial packet emitted after release.
- Beat handshake = tvalid & tready on the same rising edge.
- Write pointers: wr_ptr (speculative) and wr_commit, both $clog2(DEPTH)+1 bits with a wrap bit; full when wr_ptr - rd_ptr == DEPTH.
- Write FSM:
  - IDLE/STORE: s_axis_tready = !full && pkt_level_pending < PKT_DEPTH. Each accepted beat is written at wr_ptr, and wr_ptr increments.
  - tlast accepted with tuser[0]=0: wr_commit <= wr_ptr+1, pkt_pass_count++, packet is queued.
  - tlast accepted with tuser[0]=1: wr_ptr <= wr_commit (rewind), pkt_drop_count++.
  - Oversize: beats of the current packet == DEPTH and no tlast yet -> DROP. On entry, wr_ptr <= wr_commit.
  - DROP: s_axis_tready = 1. Beats are discarded. On the tlast handshake, pkt_drop_count++, -> STORE.
  - A single-beat packet (tlast on first beat) is legal.
- Read side:
  - Reads only from committed data (rd_ptr != wr_commit).
  - Registered RAM read plus a 2-entry output skid buffer.
  - m_axis_tvalid first rises exactly 2 cycles after the tlast handshake edge when the output is idle.
  - Within a packet, m_axis_tvalid stays high every cycle until tlast while m_axis_tready=1. No bubbles are allowed.
  - Back-to-back committed packets are emitted with zero idle cycles between them.
  - Output holds data/keep/last stable while tvalid=1 and tready=0.
  - Output tlast comes from the stored tlast bit. tkeep is passed through unmodified.
- pkt_level: +1 on commit, -1 on the output tlast handshake; both in the same cycle -> unchanged.
- Simultaneous commit and last-beat read of the preceding packet: both take effect; empty-to-nonempty is handled without a lost beat.
- All counters wrap modulo 2^32 with no saturation.

Test Plan:
- Single 4-beat packet, tuser=0, m_axis_tready=1 -> tvalid rises 2 cycles after tlast is accepted; 4 contiguous beats with identical data/keep; tlast on beat 4; pkt_pass_count=1.
- 4-beat packet with tuser[0]=1 on tlast, followed by a good 2-beat packet -> only the 2-beat packet appears; pkt_drop_count=1, pkt_pass_count=1.
- DEPTH=64, 70-beat packet then a 3-beat good packet -> the 70-beat packet is dropped (s_axis_tready stays 1 after beat 64); the 3-beat packet is output intact; pkt_drop_count=1.
- Input tvalid toggled 50% within a 10-beat packet -> output has 10 contiguous tvalid cycles with no gaps.
- Random m_axis_tready backpressure, 200 random-length packets (1–40 beats) -> output data stream equals the input; s_axis_tready drops only when full; pkt_level never exceeds PKT_DEPTH.
- Reset asserted during beat 3 of 6 on output and beat 2 of 5 on input -> all outputs 0 immediately; after release, no residual beats appear; a new packet passes normally.
